// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RGB565 pixel type and sprite fetch FSM states.
package vga_pkg;

  localparam int HACTIVE = 1280;
  localparam int VACTIVE = 480;
  localparam int VTOTAL  = 525;

  localparam logic [15:0] KEY_RGB565 = 16'hF81F;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of RGB565 pixels: single synchronous write port, asynchronous read port.
module sprite_line_buf
  import vga_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb565_t       wdata,
  input  logic [AW-1:0] raddr,
  output rgb565_t       rdata
);

  // No reset on the storage: contents are only shown once a complete row has been written.
  rgb565_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sprite_line_fetch.sv
// Prefetches one sprite row from ROM during horizontal blanking and streams it during active video.
// Optional build macro TRANSPARENT_KEY_EN: pixels equal to the magenta key are shown as transparent.
//
// state | meaning
// IDLE  | waiting for the start of horizontal blanking
// FETCH | issuing one ROM address per clk for the next line's sprite row
// DRAIN | writing the last returned ROM word, then marking the line buffer valid
module sprite_line_fetch
  import vga_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int ROM_AW   = 10,
  parameter int HACTIVE  = vga_pkg::HACTIVE,
  parameter int VTOTAL   = vga_pkg::VTOTAL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_rdata,
  output logic [15:0]       pix_rgb,
  output logic              pix_valid,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [10:0] HACT_C  = 11'(HACTIVE);
  localparam logic [9:0]  VACT_C  = 10'(VACTIVE);
  localparam logic [9:0]  VLAST_C = 10'(VTOTAL - 1);
  localparam logic [10:0] SW_C    = 11'(SPRITE_W);
  localparam logic [10:0] SH_C    = 11'(SPRITE_H);
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic          line_ok_q, line_ok_d;
  logic          underrun_q, underrun_d;
  logic [9:0]    x_s_q, x_s_d;
  logic [9:0]    y_s_q, y_s_d;
  logic          en_s_q, en_s_d;
  rgb565_t       pix_rgb_q, pix_rgb_d;
  logic          pix_valid_q, pix_valid_d;

  logic [9:0]    next_row;
  logic [10:0]   drow;
  logic          row_hit;
  logic          wr_en;
  logic [CW-1:0] wr_addr;
  logic [10:0]   col;
  logic [CW-1:0] lbuf_raddr;
  rgb565_t       rom_px;
  rgb565_t       lbuf_px;

  assign next_row = (vcount == VLAST_C) ? 10'd0 : vcount + 10'd1;
  assign drow     = {1'b0, next_row} - {1'b0, y_s_q};
  assign row_hit  = en_s_q && (drow < SH_C);

  always_comb begin
    x_s_d = x_s_q;
    y_s_d = y_s_q;
    en_s_d = en_s_q;
    if (hcount == 11'd0 && vcount == VLAST_C) begin
      x_s_d  = sprite_x;
      y_s_d  = sprite_y;
      en_s_d = sprite_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_cnt_d  = col_cnt_q;
    line_ok_d  = line_ok_q;
    underrun_d = underrun_q;
    if (hcount == 11'd0 && state_q != ST_IDLE) begin
      underrun_d = 1'b1;
      line_ok_d  = 1'b0;
      state_d    = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hcount == HACT_C) begin
            line_ok_d = 1'b0;
            if (row_hit) begin
              state_d   = ST_FETCH;
              row_d     = drow[RW-1:0];
              col_cnt_d = '0;
            end
          end
        end
        ST_FETCH: begin
          col_cnt_d = col_cnt_q + CW'(1);
          if (col_cnt_q == COL_LAST) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          line_ok_d = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ROM data lags its address by one clk, so each write lands one column behind the counter.
  assign wr_en   = (state_q == ST_FETCH && col_cnt_q != '0) || (state_q == ST_DRAIN);
  assign wr_addr = col_cnt_q - CW'(1);
  assign rom_px  = rom_rdata;

  assign rom_addr = (state_q == ST_FETCH) ? ROM_AW'({row_q, col_cnt_q}) : '0;

  sprite_line_buf #(
    .DEPTH (SPRITE_W)
  ) u_lbuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (rom_px),
    .raddr (lbuf_raddr),
    .rdata (lbuf_px)
  );

  assign col        = {1'b0, hcount[10:1]} - {1'b0, x_s_q};
  assign lbuf_raddr = col[CW-1:0];

  always_comb begin
    pix_valid_d = line_ok_q && (hcount < HACT_C) && (vcount < VACT_C) && (col < SW_C);
`ifdef TRANSPARENT_KEY_EN
    if (lbuf_px == KEY_RGB565) pix_valid_d = 1'b0;
`endif
    pix_rgb_d = pix_valid_d ? lbuf_px : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_cnt_q   <= '0;
      line_ok_q   <= 1'b0;
      underrun_q  <= 1'b0;
      x_s_q       <= '0;
      y_s_q       <= '0;
      en_s_q      <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_cnt_q   <= col_cnt_d;
      line_ok_q   <= line_ok_d;
      underrun_q  <= underrun_d;
      x_s_q       <= x_s_d;
      y_s_q       <= y_s_d;
      en_s_q      <= en_s_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign pix_rgb    = pix_rgb_q;
  assign pix_valid  = pix_valid_q;
  assign fetch_busy = (state_q != ST_IDLE);
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: frame-level sprite model checked every clk plus directed literal checks.
module tb_sprite_line_fetch;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int HACT = 1280;
  localparam int VACT = 480;
  localparam int VTOT = 525;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [9:0]  sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        sprite_en = 1'b0;
  logic [9:0]  rom_addr;
  logic [15:0] rom_rdata = '0;
  logic [15:0] pix_rgb;
  logic        pix_valid;
  logic        fetch_busy;
  logic        underrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  sprite_line_fetch #(
    .SPRITE_W (W),
    .SPRITE_H (H),
    .ROM_AW   (10),
    .HACTIVE  (HACT),
    .VTOTAL   (VTOT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_en  (sprite_en),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .pix_rgb    (pix_rgb),
    .pix_valid  (pix_valid),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  // Sprite ROM contents: word = address, except word 5 holds the magenta key.
  function automatic logic [15:0] rom_word(input int a);
    return (a == 5) ? 16'hF81F : 16'(a);
  endfunction

  always @(posedge clk) rom_rdata <= rom_word(int'(rom_addr));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level model: shadowed sprite position, which sprite row (if any) is buffered,
  // and how many clocks of the current row fetch remain.
  int m_x = 0, m_y = 0, m_en = 0, m_ok = 0, m_row = 0, m_b = 0, m_und = 0;

  always @(posedge clk) begin : cmp
    int h, v, c, d, nr, ea;
    logic ev, eb, chk_a;
    logic [15:0] er;
    h = int'(hcount);
    v = int'(vcount);
    ev = 1'b0;
    er = '0;
    if (!reset_n) begin
      m_x = 0; m_y = 0; m_en = 0; m_ok = 0; m_row = 0; m_b = 0; m_und = 0;
    end else begin
      c = h / 2 - m_x;
      if (m_ok != 0 && h < HACT && v < VACT && c >= 0 && c < W) begin
        er = rom_word(m_row * W + c);
        ev = 1'b1;
`ifdef TRANSPARENT_KEY_EN
        if (er == 16'hF81F) begin
          ev = 1'b0;
          er = '0;
        end
`endif
      end
      if (h == 0 && v == VTOT - 1) begin
        m_x = int'(sprite_x);
        m_y = int'(sprite_y);
        m_en = int'(sprite_en);
      end
      if (h == 0 && m_b > 0) begin
        m_und = 1; m_b = 0; m_ok = 0;
      end else if (m_b > 0) begin
        m_b--;
        if (m_b == 0) m_ok = 1;
      end else if (h == HACT) begin
        nr = (v == VTOT - 1) ? 0 : v + 1;
        d = nr - m_y;
        m_ok = 0;
        if (m_en != 0 && d >= 0 && d < H) begin
          m_b = W + 1;
          m_row = d;
        end
      end
    end
    eb = (m_b > 0);
    chk_a = (m_b > 1);
    ea = m_row * W + (W + 1 - m_b);
    #1;
    check("pix_valid", pix_valid, ev);
    check("pix_rgb", pix_rgb, er);
    check("fetch_busy", fetch_busy, eb);
    check("underrun", underrun, m_und[0]);
    if (chk_a) check("rom_addr", rom_addr, ea);
  end

  logic        pv_log [640];
  logic [15:0] rgb_log [640];
  logic [9:0]  addr_log [$];
  int          n_vld, busy_cnt;

  task automatic tick(input int h, input int v);
    @(negedge clk);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    #2;
  endtask

  task automatic blank(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      tick(h, v);
      if (fetch_busy) begin
        busy_cnt++;
        addr_log.push_back(rom_addr);
      end
    end
  endtask

  // Condensed line: start of line, active window around pixel px, then the blanking fetch window.
  task automatic run_line(input int v, input int px);
    int lo, hi;
    for (int i = 0; i < 640; i++) begin
      pv_log[i] = 1'b0;
      rgb_log[i] = '0;
    end
    n_vld = 0;
    busy_cnt = 0;
    addr_log.delete();
    tick(0, v);
    lo = 2 * px - 4;
    if (lo < 1) lo = 1;
    hi = 2 * px + 2 * W + 4;
    if (hi > HACT - 1) hi = HACT - 1;
    for (int h = lo; h <= hi; h++) begin
      tick(h, v);
      if (h % 2 == 0) begin
        pv_log[h / 2] = pix_valid;
        rgb_log[h / 2] = pix_rgb;
      end
      if (pix_valid) n_vld++;
    end
    blank(v, HACT, HACT + 50);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_rgb", pix_rgb, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_fetch_busy", fetch_busy, 0);
    check("rst_underrun", underrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    sprite_en = 1'b1;

    // Sprite at (100,50)
    run_line(524, 100);
    check("f1_l524_busy", busy_cnt, 0);
    run_line(48, 100);
    run_line(49, 100);
    check("l49_busy_clk", busy_cnt, 33);
    check("l49_addr_first", addr_log[0], 0);
    check("l49_addr_last", addr_log[31], 31);
    check("l49_no_display", n_vld, 0);
    run_line(50, 100);
    check("l50_px99_vld", pv_log[99], 0);
    check("l50_px100_vld", pv_log[100], 1);
    check("l50_px100_rgb", rgb_log[100], 16'h0000);
    check("l50_px131_vld", pv_log[131], 1);
    check("l50_px131_rgb", rgb_log[131], 16'h001F);
    check("l50_px132_vld", pv_log[132], 0);
    check("l50_px106_rgb", rgb_log[106], 16'h0006);
`ifdef TRANSPARENT_KEY_EN
    check("l50_px105_key_vld", pv_log[105], 0);
    check("l50_px104_vld", pv_log[104], 1);
    check("l50_px106_vld", pv_log[106], 1);
`else
    check("l50_px105_vld", pv_log[105], 1);
    check("l50_px105_rgb", rgb_log[105], 16'hF81F);
`endif
    run_line(51, 100);
    check("l51_px101_rgb", rgb_log[101], 16'h0021);

    // Mid-frame position write must not move the current frame
    sprite_x = 10'd300;
    run_line(80, 100);
    run_line(81, 100);
    check("l81_px100_vld", pv_log[100], 1);
    check("l81_px100_rgb", rgb_log[100], 16'd992);
    check("l81_px131_rgb", rgb_log[131], 16'd1023);
    run_line(82, 100);
    check("l82_no_display", n_vld, 0);

    // Move to row 200 at line 300: takes effect next frame
    sprite_x = 10'd100;
    sprite_y = 10'd200;
    run_line(300, 100);
    run_line(524, 100);
    run_line(49, 100);
    run_line(50, 100);
    check("f2_l50_no_display", n_vld, 0);
    run_line(199, 100);
    run_line(200, 100);
    check("f2_l200_px100_vld", pv_log[100], 1);
    check("f2_l200_px100_rgb", rgb_log[100], 16'd0);
    run_line(201, 100);
    check("f2_l201_px100_rgb", rgb_log[101], 16'd33);

    // y=0 at the right edge: fetched during line 524, clipped at column 639
    sprite_y = 10'd0;
    sprite_x = 10'd620;
    run_line(300, 620);
    run_line(524, 620);
    check("y0_l524_busy_clk", busy_cnt, 33);
    check("y0_l524_addr_last", addr_log[31], 31);
    run_line(0, 620);
    check("y0_px619_vld", pv_log[619], 0);
    check("y0_px620_vld", pv_log[620], 1);
    check("y0_px620_rgb", rgb_log[620], 16'd0);
    check("y0_px639_rgb", rgb_log[639], 16'd19);
`ifdef TRANSPARENT_KEY_EN
    check("y0_vld_ticks", n_vld, 38);
`else
    check("y0_vld_ticks", n_vld, 40);
`endif

    // Disabled sprite: no fetch, no display
    sprite_en = 1'b0;
    run_line(524, 620);
    check("dis_l524_busy", busy_cnt, 0);
    run_line(0, 620);
    check("dis_l0_no_display", n_vld, 0);

    // Forced underrun: line start while a fetch is running
    sprite_en = 1'b1;
    sprite_y = 10'd50;
    sprite_x = 10'd100;
    run_line(524, 100);
    busy_cnt = 0;
    addr_log.delete();
    tick(0, 49);
    blank(49, HACT, HACT + 10);
    check("ur_busy_before", fetch_busy, 1);
    check("ur_flag_before", underrun, 0);
    tick(0, 49);
    check("ur_flag_set", underrun, 1);
    check("ur_busy_abort", fetch_busy, 0);
    blank(49, HACT + 11, HACT + 50);
    run_line(50, 100);
    check("ur_l50_no_display", n_vld, 0);
    check("ur_flag_sticky", underrun, 1);

    // Reset mid-fetch
    run_line(524, 100);
    tick(0, 49);
    blank(49, HACT, HACT + 9);
    check("rst2_busy_before", fetch_busy, 1);
    @(negedge clk);
    hcount = 11'(HACT + 10);
    reset_n = 1'b0;
    #1;
    check("rst2_pix_valid", pix_valid, 0);
    check("rst2_pix_rgb", pix_rgb, 0);
    check("rst2_rom_addr", rom_addr, 0);
    check("rst2_fetch_busy", fetch_busy, 0);
    check("rst2_underrun", underrun, 0);
    for (int h = HACT + 11; h <= HACT + 13; h++) tick(h, 49);
    @(negedge clk);
    reset_n = 1'b1;
    busy_cnt = 0;
    blank(49, HACT + 14, HACT + 50);
    check("rst2_no_refetch", busy_cnt, 0);
    run_line(50, 100);
    check("rst2_l50_no_display", n_vld, 0);
    run_line(524, 100);
    run_line(49, 100);
    check("rst2_l49_busy_clk", busy_cnt, 33);
    run_line(50, 100);
    check("rst2_l50_px100_vld", pv_log[100], 1);
    check("rst2_l50_px131_rgb", rgb_log[131], 16'h001F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
